wb_qcw_ramp_ctrl: RTL
=====================

WB_QCW_RAMP_CTRL -- requirements
Module: wb_qcw_ramp_ctrl

Interface
REQ-001 SHALL have parameters: BASE_ADR, default 32'h1000000, byte base address; PHASE_W, default 8, phase width; FRAC_W, default 8, step fraction bits; CYCLE_W, default 16, cycle counter width; CUR_W, default 10, current width.
REQ-002 SHALL have ports:
- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables, ignored (full-word access)
- wb_we_i  in  1  write
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  ack
- wb_dat_o  out  32  read data
- qcw_start  out  1  run-start pulse
- qcw_enable  out  1  high while running
- qcw_cycle_limit  out  CYCLE_W  latched limit
- qcw_phase_shift  out  PHASE_W  current phase
- qcw_done  in  1  bridge run complete
- qcw_cycle_finished  in  1  one-cycle pulse per drive cycle
- qcw_fault  in  1  fault level
- qcw_halt  in  1  halt level
- qcw_current  in  CUR_W  sampled current
- irq_o  out  1  level interrupt

Function
REQ-003 SHALL decode word offsets: 0x00 CTRL (W: bit0 start, bit1 abort, self-clearing; bit2 mode, 0 = ramp up, 1 = ramp down, readable), 0x04 PHASE_START, 0x08 PHASE_STEP (PHASE_W+FRAC_W bits), 0x0C PHASE_MAX, 0x10 CYCLE_LIMIT, 0x14 STATUS, 0x18 IRQ_EN, 0x1C CURRENT (RO), 0x20 PEAK_CURRENT (RO), 0x24 CYCLE_COUNT (RO).
REQ-004 SHALL assert wb_ack_o for exactly one cycle, one cycle after cyc&stb with the address in [BASE_ADR, BASE_ADR+0x24]; SHALL deassert it for at least one cycle between acks; out-of-range addresses SHALL NOT be acked.
REQ-005 Unused in-range word-aligned or unaligned addresses SHALL ack with read data 0 and ignore writes; reads SHALL zero-extend; writes SHALL truncate to register width.
REQ-006 STATUS: bit0 busy (RO), bit1 done, bit2 fault, bit3 halt, bit4 aborted; bits1-4 sticky, cleared by write-1; set takes priority over clear in the same cycle.
REQ-007 irq_o SHALL equal OR of (STATUS[4:1] & IRQ_EN[3:0]), registered.
REQ-008 FSM states IDLE, ARM, RUN, STOP; IDLE->ARM on start write if CYCLE_LIMIT != 0 and qcw_fault low, otherwise start is ignored with no status change; start while not IDLE is ignored.
REQ-009 ARM lasts one cycle: latch PHASE_START, PHASE_STEP, PHASE_MAX, CYCLE_LIMIT, mode into working copies; qcw_phase_shift <= PHASE_START; clear accumulator, cycle count, PEAK_CURRENT; qcw_start = 1 in this cycle only.
REQ-010 RUN: qcw_enable = 1; on each qcw_cycle_finished, cycle count +1, accumulator += step (saturating at its full width), phase <= clamp(PHASE_START ± accumulator[top PHASE_W bits]). Up mode clamps at min(PHASE_MAX, 2^PHASE_W-1); down mode floors at 0.
REQ-011 RUN->STOP when any of the following occurs: qcw_done; count reaches latched limit; qcw_fault; qcw_halt; abort write. STOP sets the matching sticky bit(s), all that apply; count reaching the limit sets done.
REQ-012 If qcw_cycle_finished coincides with a terminating event, the count and phase update SHALL still be applied.
REQ-013 STOP lasts one cycle, qcw_enable = 0, then IDLE; qcw_phase_shift SHALL hold its last value until the next ARM.
REQ-014 PEAK_CURRENT SHALL track max(qcw_current) sampled each cycle in RUN; CURRENT SHALL read live input.
REQ-015 Config writes during RUN SHALL update registers and take effect at the next ARM only.

Reset
REQ-016 On wb_rst_ni low, asynchronously: FSM IDLE; all registers, sticky bits, counters, accumulator 0; wb_ack_o, wb_dat_o, qcw_start, qcw_enable, qcw_phase_shift, qcw_cycle_limit, irq_o 0.
REQ-017 Reset asserted mid-RUN SHALL drop qcw_enable immediately, and no sticky bit SHALL be set.

Verification
REQ-018 Ramp up: START=10, STEP=0x0180, MAX=200, LIMIT=4, 4 cycle_finished pulses -> phase 10,11,13,14,16; done sticky; one qcw_start pulse; CYCLE_COUNT=4.
REQ-019 Clamp/floor: up mode START=250, STEP=0x1000, MAX=255 -> phase 255 held; down mode START=5, STEP=0x0400 -> 5,1,0,0.
REQ-020 Fault mid-run at count 2 coincident with cycle_finished -> count 3, fault sticky, irq_o=1 with IRQ_EN=0x2, qcw_enable low 2 cycles later; then start with fault high ignored.
REQ-021 Bus: read 0x28 past base -> no ack; read unused in-range 0x1A -> ack, data 0; back-to-back stb -> acks separated by at least one low cycle; STATUS write 0x1E clears sticky bits.
REQ-022 Start with LIMIT=0 ignored; abort in RUN -> aborted bit set; wb_rst_ni low mid-RUN -> all outputs 0 asynchronously, STATUS=0 after release.

Source files
------------

// File: rtl/wb_qcw_ramp_ctrl.sv
// wb_qcw_ramp_ctrl: Wishbone-controlled QCW phase-ramp sequencer with sticky status and interrupt
module wb_qcw_ramp_ctrl #(
  parameter logic [31:0] BASE_ADR = 32'h1000000,
  parameter int PHASE_W = 8,
  parameter int FRAC_W = 8,
  parameter int CYCLE_W = 16,
  parameter int CUR_W = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic               wb_ack_o,
  output logic [31:0]        wb_dat_o,
  output logic               qcw_start,
  output logic               qcw_enable,
  output logic [CYCLE_W-1:0] qcw_cycle_limit,
  output logic [PHASE_W-1:0] qcw_phase_shift,
  input  logic               qcw_done,
  input  logic               qcw_cycle_finished,
  input  logic               qcw_fault,
  input  logic               qcw_halt,
  input  logic [CUR_W-1:0]   qcw_current,
  output logic               irq_o
);
  localparam int ACC_W = PHASE_W + FRAC_W;
  typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;
  state_t state, state_n;
  logic [31:0] off, rd;
  logic [3:0] idx, sticky, irq_en, ev, set_b, clr_b;
  logic req, wr, start_req, abort_req, go, stop, mode, w_mode, unused_bits;
  logic [PHASE_W-1:0] phase_start, phase_max, w_start, w_max, delta, phase_up, phase_dn;
  logic [PHASE_W:0] up_sum;
  logic [ACC_W-1:0] phase_step, w_step, acc, acc_nxt;
  logic [ACC_W:0] acc_sum;
  logic [CYCLE_W-1:0] cycle_limit, count, cnt_nxt;
  logic [CUR_W-1:0] peak;

  assign unused_bits = ^{wb_sel_i, wb_dat_i[31:ACC_W]};
  assign off = wb_adr_i - BASE_ADR;
  assign idx = off[5:2];
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & (wb_adr_i >= BASE_ADR) & (off <= 32'h24);
  assign wr = req & wb_we_i & (off[1:0] == 2'b00);
  assign start_req = wr & (idx == 4'd0) & wb_dat_i[0];
  assign abort_req = wr & (idx == 4'd0) & wb_dat_i[1];
  assign go = (state == IDLE) & start_req & (cycle_limit != '0) & ~qcw_fault;
  assign acc_sum = {1'b0, acc} + {1'b0, w_step};
  assign acc_nxt = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  assign delta = acc_nxt[ACC_W-1:FRAC_W];
  assign up_sum = {1'b0, w_start} + {1'b0, delta};
  assign phase_up = (up_sum > {1'b0, w_max}) ? w_max : up_sum[PHASE_W-1:0];
  assign phase_dn = (delta > w_start) ? '0 : w_start - delta;
  assign cnt_nxt = count + CYCLE_W'(qcw_cycle_finished);
  assign ev = {abort_req, qcw_halt, qcw_fault, qcw_done | (cnt_nxt == qcw_cycle_limit)};
  assign stop = (state == RUN) & (|ev);
  assign set_b = stop ? ev : '0;
  assign clr_b = (wr & (idx == 4'd5)) ? wb_dat_i[4:1] : '0;
  assign qcw_start = (state == ARM);
  assign qcw_enable = (state == RUN);

  // Read mux; unaligned or unused offsets read as zero
  always_comb begin
    rd = '0;
    if (off[1:0] == 2'b00)
      case (idx)
        4'd0: rd = {29'd0, mode, 2'b00};
        4'd1: rd = 32'(phase_start);
        4'd2: rd = 32'(phase_step);
        4'd3: rd = 32'(phase_max);
        4'd4: rd = 32'(cycle_limit);
        4'd5: rd = {27'd0, sticky, state != IDLE};
        4'd6: rd = {28'd0, irq_en};
        4'd7: rd = 32'(qcw_current);
        4'd8: rd = 32'(peak);
        4'd9: rd = 32'(count);
        default: rd = '0;
      endcase
  end

  // Next-state: ARM and STOP are single-cycle transit states
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = go ? ARM : IDLE;
      ARM: state_n = RUN;
      RUN: state_n = stop ? STOP : RUN;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) state <= IDLE;
    else state <= state_n;

  // Bus response: ack one cycle after the request, never two in a row
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rd : '0;
    end

  // Configuration registers, writable at any time, consumed only at ARM
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      mode <= 1'b0;
      phase_start <= '0;
      phase_step <= '0;
      phase_max <= '0;
      cycle_limit <= '0;
      irq_en <= '0;
    end else if (wr) begin
      if (idx == 4'd0) mode <= wb_dat_i[2];
      if (idx == 4'd1) phase_start <= wb_dat_i[PHASE_W-1:0];
      if (idx == 4'd2) phase_step <= wb_dat_i[ACC_W-1:0];
      if (idx == 4'd3) phase_max <= wb_dat_i[PHASE_W-1:0];
      if (idx == 4'd4) cycle_limit <= wb_dat_i[CYCLE_W-1:0];
      if (idx == 4'd6) irq_en <= wb_dat_i[3:0];
    end

  // Ramp engine: snapshot config in ARM, advance phase per drive cycle in RUN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      w_mode <= 1'b0;
      w_start <= '0;
      w_max <= '0;
      w_step <= '0;
      qcw_cycle_limit <= '0;
      qcw_phase_shift <= '0;
      acc <= '0;
      count <= '0;
      peak <= '0;
    end else if (state == ARM) begin
      w_mode <= mode;
      w_start <= phase_start;
      w_max <= phase_max;
      w_step <= phase_step;
      qcw_cycle_limit <= cycle_limit;
      qcw_phase_shift <= phase_start;
      acc <= '0;
      count <= '0;
      peak <= '0;
    end else if (state == RUN) begin
      if (qcw_current > peak) peak <= qcw_current;
      if (qcw_cycle_finished) begin
        count <= cnt_nxt;
        acc <= acc_nxt;
        qcw_phase_shift <= w_mode ? phase_dn : phase_up;
      end
    end

  // Sticky status (set wins over write-1-clear) and registered interrupt
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      sticky <= '0;
      irq_o <= 1'b0;
    end else begin
      sticky <= (sticky & ~clr_b) | set_b;
      irq_o <= |(sticky & irq_en);
    end
endmodule
